// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one 256-bit cache line read/write into a 4-beat 64-bit memory burst.
// Optional stalled-burst watchdog: define CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor #(
  parameter int LINE_WIDTH     = 256,
  parameter int BURST_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  output logic                   err_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int BEAT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [BEAT_BITS-1:0]   beat_reg, beat_next;
  logic [LINE_WIDTH-1:0]  wline_reg, wline_next;
  logic [LINE_WIDTH-1:0]  rline_reg, rline_next;
  logic [31:0]            addr_reg, addr_next;
  logic                   err_reg, err_next;
  logic                   timeout;
  logic [BURST_WIDTH-1:0] wbeat [BEATS];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
      assign wbeat[gi] = wline_reg[gi*BURST_WIDTH +: BURST_WIDTH];
    end
  endgenerate

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_BITS-1:0] tmo_reg, tmo_next;
  logic                busy;

  // Counter is zero on entry to READ/WRITE because it is cleared whenever not busy.
  assign busy    = (state_reg == READ) || (state_reg == WRITE);
  assign timeout = busy && !resp_i && (tmo_reg == TMO_BITS'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_next = '0;
    if (busy && !resp_i) tmo_next = tmo_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_reg <= '0;
    else     tmo_reg <= tmo_next;
  end
`else
  // No watchdog: the burst waits on memory indefinitely.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      wline_reg <= '0;
      rline_reg <= '0;
      addr_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      wline_reg <= wline_next;
      rline_reg <= rline_next;
      addr_reg  <= addr_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    wline_next = wline_reg;
    rline_next = rline_reg;
    addr_next  = addr_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Writeback wins over fill when both are requested.
        if (write_i || read_i) begin
          addr_next  = {address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          beat_next  = '0;
          state_next = write_i ? WRITE : READ;
          if (write_i) wline_next = line_i;
        end
      end
      READ, WRITE: begin
        if (timeout) begin
          beat_next  = '0;
          err_next   = 1'b1;
          state_next = DONE;
        end else if (resp_i) begin
          if (state_reg == READ)
            rline_next[beat_reg*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            state_next = DONE;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign line_o    = rline_reg;
  assign burst_o   = wbeat[beat_reg];
  assign address_o = addr_reg;
  assign read_o    = (state_reg == READ);
  assign write_o   = (state_reg == WRITE);
  assign resp_o    = (state_reg == DONE);
  assign err_o     = err_reg;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: scoreboard of expected lines/beats, checked at DONE.
module tb_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o, err_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  cacheline_adaptor #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .resp_o(resp_o), .err_o(err_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_write;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  exp_t         exp_q[$];
  logic [63:0]  wbeat_q[$];
  logic [255:0] last_rline;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // gaps: idle resp_i cycles before beat b in gaps[b*4+:4]; poke: disturb request inputs while busy.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input logic [15:0] gaps, input bit poke);
    exp_t        e;
    exp_t        got_e;
    int          k;
    logic [31:0] exp_addr;
    exp_addr   = {addr[31:5], 5'b0};
    e.is_write = wr;
    e.addr     = exp_addr;
    e.line     = wr ? wline : rline;
    exp_q.push_back(e);
    if (wr) for (int b = 0; b < 4; b++) wbeat_q.push_back(wline[b*64 +: 64]);
    address_i = addr; line_i = wline; write_i = wr; read_i = rd;
    @(negedge clk);
    write_i = 1'b0; read_i = 1'b0;
    check_eq("addr_o", address_o, exp_addr);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < int'(gaps[b*4 +: 4]); g++) begin
        if (poke) begin
          address_i = 32'hFFFF_FFE0;
          read_i    = 1'b1;
        end
        check_eq("gap_read_o", read_o, !wr);
        check_eq("gap_write_o", write_o, wr);
        if (wr) check_eq("gap_burst_o", burst_o, wbeat_q[0]);
        @(negedge clk);
        check_eq("gap_addr_o", address_o, exp_addr);
      end
      check_eq("beat_read_o", read_o, !wr);
      check_eq("beat_write_o", write_o, wr);
      if (wr) check_eq("burst_o", burst_o, wbeat_q.pop_front());
      burst_i = rline[b*64 +: 64];
      resp_i  = 1'b1;
      @(negedge clk);
      resp_i  = 1'b0;
      burst_i = '0;
    end
    k = 0;
    while (!resp_o && k < 4) begin
      @(negedge clk);
      k++;
    end
    read_i = 1'b0;
    check_eq("resp_latency", k, 0);
    check_eq("resp_o", resp_o, 1'b1);
    check_eq("err_o", err_o, 1'b0);
    check_eq("done_read_o", read_o, 1'b0);
    check_eq("done_write_o", write_o, 1'b0);
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      check_eq("done_addr_o", address_o, got_e.addr);
      if (got_e.is_write) check_eq("line_o_hold", line_o, last_rline);
      else                check_eq("line_o", line_o, got_e.line);
      if (!got_e.is_write) last_rline = got_e.line;
    end
    @(negedge clk);
    check_eq("resp_o_pulse", resp_o, 1'b0);
    check_eq("idle_read_o", read_o, 1'b0);
    check_eq("idle_write_o", write_o, 1'b0);
    $display("txn %s addr=%h gaps=%h poke=%0d done", wr ? "write" : "read", addr, gaps, poke);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    logic [255:0] wl;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0; last_rline = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_read_o", read_o, 1'b0);
    check_eq("rst_write_o", write_o, 1'b0);
    check_eq("rst_resp_o", resp_o, 1'b0);
    check_eq("rst_err_o", err_o, 1'b0);
    check_eq("rst_address_o", address_o, 32'h0);
    check_eq("rst_line_o", line_o, 256'h0);
    check_eq("rst_burst_o", burst_o, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // memory response while idle must not start anything
    resp_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b0;
    check_eq("idle_resp_read_o", read_o, 1'b0);
    check_eq("idle_resp_resp_o", resp_o, 1'b0);

    // line fill, back-to-back beats
    run_txn(1'b0, 1'b1, 32'h1234_5678, '0,
            {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}}, 16'h0000, 1'b0);

    // writeback with resp_i on cycles 1, 3, 4, 7
    wl = rand_line();
    run_txn(1'b1, 1'b0, 32'h0000_ABCD, wl, '0, 16'h2010, 1'b0);

    // simultaneous read/write request: write wins
    wl = rand_line();
    run_txn(1'b1, 1'b1, 32'h8000_0040, wl, '0, 16'h0100, 1'b0);

    // busy isolation: address/read_i disturbed during the write
    wl = rand_line();
    run_txn(1'b1, 1'b0, 32'h0000_1000, wl, '0, 16'h1111, 1'b1);

    // fill with irregular gaps
    wl = rand_line();
    run_txn(1'b0, 1'b1, 32'h7654_321F, '0, wl, 16'h3102, 1'b0);

    // reset mid-burst after two read beats
    address_i = 32'h0000_2000; read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      burst_i = {2{$urandom}}; resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0;
    check_eq("pre_rst_read_o", read_o, 1'b1);
    #1 rst = 1'b1;
    #1 check_eq("async_rst_read_o", read_o, 1'b0);
    check_eq("async_rst_line_o", line_o, 256'h0);
    #1 rst = 1'b0;
    last_rline = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_resp_o", resp_o, 1'b0);
    end

    wl = rand_line();
    run_txn(1'b0, 1'b1, 32'h0000_2000, '0, wl, 16'h0000, 1'b0);

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    begin
      int k;
      address_i = 32'h0000_3000; read_i = 1'b1;
      @(negedge clk);
      read_i = 1'b0;
      k = 0;
      while (!resp_o && k < 20) begin
        check_eq("tmo_read_o", read_o, 1'b1);
        @(negedge clk);
        k++;
      end
      check_eq("tmo_cycles", k, 8);
      check_eq("tmo_resp_o", resp_o, 1'b1);
      check_eq("tmo_err_o", err_o, 1'b1);
      check_eq("tmo_read_o_low", read_o, 1'b0);
      @(negedge clk);
      check_eq("tmo_resp_o_pulse", resp_o, 1'b0);
      check_eq("tmo_err_o_pulse", err_o, 1'b0);
      $display("txn read addr=00003000 timeout done");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
